foo_coeff_sequencer: RTL and testbench
======================================

# foo_coeff_sequencer

Row-wise coefficient source for the FOO correction datapath. Holds a CPU-loaded table of per-row R/G/B gain triplets. Walks the table in step with frame and line timing, and presents each row's coefficient vector, row parity and the 2-stage pipeline enables at the correction block's inputs. The correction block consumes these; this block produces them.

## Interface
Parameters:
- p_foo_gain_bit, 10, width of one gain
- p_rgb_num_bit, 3, gains per entry (R, G, B; R in LSBs)
- p_tbl_addr_bit, 6, table depth = 2^p_tbl_addr_bit entries
- p_row_bit, 13, row counter width
- p_row_sft_bit, 3, width of rows-per-entry shift register field
- p_pipeline_num_bit, 2, pipeline enable vector width

Ports:
- i_CLK  in  1  clock
- i_RSTn  in  1  reset; one clock, reset asynchronous active-low
- i_WR_EN  in  1  table write strobe
- i_WR_ADDR  in  p_tbl_addr_bit  table write address
- i_WR_DATA  in  p_rgb_num_bit*p_foo_gain_bit  table write data
- i_SWAP_REQ  in  1  pulse: request bank swap at next frame start
- i_FRAME_START  in  1  pulse, one cycle
- i_LINE_START  in  1  pulse, one cycle
- i_PIX_VALID  in  1  pixel pair valid at correction input
- i_REG_ROW_SFT  in  p_row_sft_bit  rows per entry = 2^value
- i_REG_Y_OFS  in  1  parity of first active row
- i_ERR_CLR  in  1  clears o_ERR
- o_COEFF_VEC  out  p_rgb_num_bit*p_foo_gain_bit  current row gains
- o_COEFF_VLD  out  1  o_COEFF_VEC valid for current line
- o_Y_LSB  out  1  row parity for Bayer select
- o_ENA_VEC  out  p_pipeline_num_bit  correction pipeline enables
- o_ROW_IDX  out  p_row_bit  current row
- o_SWAP_PEND  out  1  swap requested, not yet applied
- o_ERR  out  1  sticky: pixel valid outside LINE_ACTIVE

## Operation
- States: IDLE -> (FRAME_START) WAIT_LINE -> (LINE_START) FETCH -> (1 cycle) LINE_ACTIVE. From LINE_ACTIVE, LINE_START goes to FETCH, FRAME_START goes to WAIT_LINE.
- Row counter: cleared by FRAME_START. The first LINE_START after it is row 0; each later LINE_START increments. Counter saturates at all-ones.
- Entry index = min(row >> i_REG_ROW_SFT, 2^p_tbl_addr_bit - 1).
- o_Y_LSB = row[0] XOR i_REG_Y_OFS, updated together with o_COEFF_VEC.
- o_ENA_VEC[0] = i_PIX_VALID (combinational, any state except IDLE). o_ENA_VEC[1] = o_ENA_VEC[0] registered.
- o_ERR sets when i_PIX_VALID is high outside LINE_ACTIVE. Affected pixels use the stale coefficients. i_ERR_CLR clears o_ERR. A simultaneous set wins.
- FRAME_START and LINE_START in the same cycle: frame restart, and that line is row 0.
- Table RAM is not reset. Read-before-write on an address collision.
- Reset mid-frame: state IDLE, row 0, bank select 0, swap pending cleared, table contents kept.

## Timing
- Reset values: o_COEFF_VEC 0, o_COEFF_VLD 0, o_Y_LSB 0, o_ENA_VEC 0, o_ROW_IDX 0, o_SWAP_PEND 0, o_ERR 0.
- LINE_START sampled at edge t: RAM read issued at edge t+1 (FETCH). o_COEFF_VEC, o_Y_LSB and o_ROW_IDX update, and o_COEFF_VLD rises, at edge t+2.
- o_COEFF_VLD drops at edge t+1 of the next LINE_START or FRAME_START.
- The first i_PIX_VALID of a line must arrive no earlier than the cycle after edge t+2.
- Coefficients are held stable for the whole line.

## Configuration
- FOO_COEFF_DBUF_EN defined:
  - Two banks. Writes go to the shadow bank.
  - i_SWAP_REQ sets o_SWAP_PEND. The next FRAME_START flips the active bank and clears o_SWAP_PEND.
  - A swap request arriving in the same cycle as FRAME_START applies immediately.
- FOO_COEFF_DBUF_EN undefined:
  - Single bank. Writes are visible from the next FETCH.
  - i_SWAP_REQ is ignored and o_SWAP_PEND is tied to 0.

## Structure
- Shared package foo_pkg: gain width, RGB count, the coefficient-vector type, and state encoding constants. The correction block uses the same gain and vector definitions.
- One sub-module: foo_coeff_tbl_ram, a 1W/1R synchronous RAM with 1-cycle read latency, instantiated once or twice depending on FOO_COEFF_DBUF_EN.

## Test plan
- Load entries 0..3 = {R,G,B}=(0x100,0x200,0x300)+i, ROW_SFT=0, Y_OFS=0. FRAME_START, then 4 LINE_STARTs 8 cycles apart -> rows 0..3 carry entry i, O_Y_LSB 0,1,0,1, each valid 2 cycles after its LINE_START.
- ROW_SFT=2, 10 lines -> entry index 0,0,0,0,1,1,1,1,2,2. With 2^6+ entries' worth of rows, the index clamps at 63.
- PIX_VALID in the cycle after LINE_START -> o_ERR=1, ENA_VEC[0]=1, ENA_VEC[1]=1 one cycle later. ERR_CLR -> o_ERR=0.
- FRAME_START and LINE_START in the same cycle -> row 0, entry 0.
- DBUF: write entry 0 = 0x3FF triplet mid-frame, then SWAP_REQ.
  - Current frame keeps the old entry and o_SWAP_PEND=1.
  - After the next FRAME_START, row 0 shows 0x3FF and o_SWAP_PEND=0.
- Assert i_RSTn low during LINE_ACTIVE -> all outputs at reset values. After release, a FRAME_START/LINE_START returns table data written before the reset.

Source files
------------

// File: rtl/foo_pkg.sv
// foo_pkg: gain/vector widths and sequencer state encoding shared by the FOO correction datapath.
package foo_pkg;
  localparam int FOO_GAIN_BIT = 10;
  localparam int FOO_RGB_NUM = 3;
  localparam int FOO_VEC_BIT = FOO_GAIN_BIT * FOO_RGB_NUM;
  typedef logic [FOO_VEC_BIT-1:0] foo_coeff_vec_t;
  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_LINE   = 2'd1,
    ST_FETCH       = 2'd2,
    ST_LINE_ACTIVE = 2'd3
  } foo_seq_state_t;
endpackage

// File: rtl/foo_coeff_tbl_ram.sv
// foo_coeff_tbl_ram: 1W/1R synchronous coefficient RAM, 1-cycle read latency, read-before-write.
module foo_coeff_tbl_ram #(
  parameter int p_addr_bit = 6,
  parameter int p_data_bit = 30
) (
  input  logic                  i_CLK,
  input  logic                  i_WR_EN,
  input  logic [p_addr_bit-1:0] i_WR_ADDR,
  input  logic [p_data_bit-1:0] i_WR_DATA,
  input  logic                  i_RD_EN,
  input  logic [p_addr_bit-1:0] i_RD_ADDR,
  output logic [p_data_bit-1:0] o_RD_DATA
);
  logic [p_data_bit-1:0] mem [2**p_addr_bit];
  always_ff @(posedge i_CLK) begin
    if (i_WR_EN) mem[i_WR_ADDR] <= i_WR_DATA;
    if (i_RD_EN) o_RD_DATA <= mem[i_RD_ADDR];
  end
endmodule

// File: rtl/foo_coeff_sequencer.sv
// foo_coeff_sequencer: walks the per-row R/G/B gain table with frame/line timing.
// Define FOO_COEFF_DBUF_EN for a double-buffered table with frame-aligned bank swap.
module foo_coeff_sequencer
  import foo_pkg::*;
#(
  parameter int p_foo_gain_bit     = FOO_GAIN_BIT,
  parameter int p_rgb_num_bit      = FOO_RGB_NUM,
  parameter int p_tbl_addr_bit     = 6,
  parameter int p_row_bit          = 13,
  parameter int p_row_sft_bit      = 3,
  parameter int p_pipeline_num_bit = 2
) (
  input  logic                                    i_CLK,
  input  logic                                    i_RSTn,
  input  logic                                    i_WR_EN,
  input  logic [p_tbl_addr_bit-1:0]               i_WR_ADDR,
  input  logic [p_rgb_num_bit*p_foo_gain_bit-1:0] i_WR_DATA,
  input  logic                                    i_SWAP_REQ,
  input  logic                                    i_FRAME_START,
  input  logic                                    i_LINE_START,
  input  logic                                    i_PIX_VALID,
  input  logic [p_row_sft_bit-1:0]                i_REG_ROW_SFT,
  input  logic                                    i_REG_Y_OFS,
  input  logic                                    i_ERR_CLR,
  output logic [p_rgb_num_bit*p_foo_gain_bit-1:0] o_COEFF_VEC,
  output logic                                    o_COEFF_VLD,
  output logic                                    o_Y_LSB,
  output logic [p_pipeline_num_bit-1:0]           o_ENA_VEC,
  output logic [p_row_bit-1:0]                    o_ROW_IDX,
  output logic                                    o_SWAP_PEND,
  output logic                                    o_ERR
);
  localparam int lp_vec_bit = p_rgb_num_bit * p_foo_gain_bit;
  foo_seq_state_t state, state_nxt;
  logic [p_row_bit-1:0] row_cnt, row_shr;
  logic line_seen, fetch_d, rd_en, ena0, err_set, vld_clr, load;
  logic [p_pipeline_num_bit-1:1] ena_q;
  logic [p_tbl_addr_bit-1:0] rd_addr;
  logic [lp_vec_bit-1:0] rd_data;

  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) state <= ST_IDLE;
    else state <= state_nxt;

  always_comb
    state_nxt = i_FRAME_START ? (i_LINE_START ? ST_FETCH : ST_WAIT_LINE)
              : (state == ST_IDLE) ? ST_IDLE
              : i_LINE_START ? ST_FETCH
              : (state == ST_FETCH) ? ST_LINE_ACTIVE : state;

  always_comb begin
    rd_en   = state == ST_FETCH;
    ena0    = i_PIX_VALID && state != ST_IDLE;
    err_set = i_PIX_VALID && state != ST_LINE_ACTIVE;
    vld_clr = state == ST_FETCH || state == ST_WAIT_LINE;
    load    = state == ST_LINE_ACTIVE && fetch_d;
  end

  // line_seen distinguishes the first line of a frame (row 0) from later increments
  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      row_cnt   <= '0;
      line_seen <= 1'b0;
    end else if (i_FRAME_START) begin
      row_cnt   <= '0;
      line_seen <= i_LINE_START;
    end else if (i_LINE_START && state != ST_IDLE) begin
      row_cnt   <= (line_seen && row_cnt != '1) ? row_cnt + 1'b1 : row_cnt;
      line_seen <= 1'b1;
    end

  assign row_shr = row_cnt >> i_REG_ROW_SFT;
  assign rd_addr = (|row_shr[p_row_bit-1:p_tbl_addr_bit]) ? '1 : row_shr[p_tbl_addr_bit-1:0];

  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      fetch_d     <= 1'b0;
      ena_q       <= '0;
      o_ERR       <= 1'b0;
      o_COEFF_VEC <= '0;
      o_COEFF_VLD <= 1'b0;
      o_Y_LSB     <= 1'b0;
      o_ROW_IDX   <= '0;
    end else begin
      fetch_d     <= rd_en;
      ena_q       <= o_ENA_VEC[p_pipeline_num_bit-2:0];
      o_ERR       <= err_set ? 1'b1 : i_ERR_CLR ? 1'b0 : o_ERR;
      o_COEFF_VLD <= load ? 1'b1 : vld_clr ? 1'b0 : o_COEFF_VLD;
      if (load) begin
        o_COEFF_VEC <= rd_data;
        o_ROW_IDX   <= row_cnt;
        o_Y_LSB     <= row_cnt[0] ^ i_REG_Y_OFS;
      end
    end

  assign o_ENA_VEC = {ena_q, ena0};

`ifdef FOO_COEFF_DBUF_EN
  logic bank_sel, swap_pend;
  logic [lp_vec_bit-1:0] rd_data0, rd_data1;

  // a request coinciding with FRAME_START flips the bank at that same edge
  always_ff @(posedge i_CLK or negedge i_RSTn)
    if (!i_RSTn) begin
      bank_sel  <= 1'b0;
      swap_pend <= 1'b0;
    end else if (i_FRAME_START) begin
      bank_sel  <= bank_sel ^ (swap_pend | i_SWAP_REQ);
      swap_pend <= 1'b0;
    end else if (i_SWAP_REQ) begin
      swap_pend <= 1'b1;
    end

  foo_coeff_tbl_ram #(.p_addr_bit(p_tbl_addr_bit), .p_data_bit(lp_vec_bit)) u_bank0 (
    .i_CLK    (i_CLK),
    .i_WR_EN  (i_WR_EN && bank_sel),
    .i_WR_ADDR(i_WR_ADDR),
    .i_WR_DATA(i_WR_DATA),
    .i_RD_EN  (rd_en),
    .i_RD_ADDR(rd_addr),
    .o_RD_DATA(rd_data0)
  );

  foo_coeff_tbl_ram #(.p_addr_bit(p_tbl_addr_bit), .p_data_bit(lp_vec_bit)) u_bank1 (
    .i_CLK    (i_CLK),
    .i_WR_EN  (i_WR_EN && !bank_sel),
    .i_WR_ADDR(i_WR_ADDR),
    .i_WR_DATA(i_WR_DATA),
    .i_RD_EN  (rd_en),
    .i_RD_ADDR(rd_addr),
    .o_RD_DATA(rd_data1)
  );

  assign rd_data     = bank_sel ? rd_data1 : rd_data0;
  assign o_SWAP_PEND = swap_pend;
`else
  logic swap_req_unused;
  assign swap_req_unused = i_SWAP_REQ;

  foo_coeff_tbl_ram #(.p_addr_bit(p_tbl_addr_bit), .p_data_bit(lp_vec_bit)) u_bank0 (
    .i_CLK    (i_CLK),
    .i_WR_EN  (i_WR_EN),
    .i_WR_ADDR(i_WR_ADDR),
    .i_WR_DATA(i_WR_DATA),
    .i_RD_EN  (rd_en),
    .i_RD_ADDR(rd_addr),
    .o_RD_DATA(rd_data)
  );

  assign o_SWAP_PEND = 1'b0;
`endif
endmodule

// File: tb/tb_foo_coeff_sequencer.sv
// tb_foo_coeff_sequencer: randomized self-checking bench against a row/table reference model.
// Honors FOO_COEFF_DBUF_EN the same way the design does.
module tb_foo_coeff_sequencer;
  localparam int VB = 30;
  localparam int AB = 6;
  localparam int RB = 13;
`ifdef FOO_COEFF_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic i_CLK, i_RSTn, i_WR_EN, i_SWAP_REQ, i_FRAME_START, i_LINE_START, i_PIX_VALID;
  logic i_REG_Y_OFS, i_ERR_CLR;
  logic [AB-1:0] i_WR_ADDR;
  logic [VB-1:0] i_WR_DATA;
  logic [2:0] i_REG_ROW_SFT;
  logic [VB-1:0] o_COEFF_VEC;
  logic o_COEFF_VLD, o_Y_LSB, o_SWAP_PEND, o_ERR;
  logic [1:0] o_ENA_VEC;
  logic [RB-1:0] o_ROW_IDX;

  foo_coeff_sequencer dut (
    .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_WR_EN(i_WR_EN), .i_WR_ADDR(i_WR_ADDR),
    .i_WR_DATA(i_WR_DATA), .i_SWAP_REQ(i_SWAP_REQ), .i_FRAME_START(i_FRAME_START),
    .i_LINE_START(i_LINE_START), .i_PIX_VALID(i_PIX_VALID), .i_REG_ROW_SFT(i_REG_ROW_SFT),
    .i_REG_Y_OFS(i_REG_Y_OFS), .i_ERR_CLR(i_ERR_CLR), .o_COEFF_VEC(o_COEFF_VEC),
    .o_COEFF_VLD(o_COEFF_VLD), .o_Y_LSB(o_Y_LSB), .o_ENA_VEC(o_ENA_VEC),
    .o_ROW_IDX(o_ROW_IDX), .o_SWAP_PEND(o_SWAP_PEND), .o_ERR(o_ERR)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // reference model: two banks (only bank 0 used without double buffering)
  logic [VB-1:0] mtbl [2][64];
  logic [VB-1:0] ld [64];
  int mact, mrow, total, bad;
  bit mfirst, mpend;

  task automatic tick;
    @(posedge i_CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [VB-1:0] d);
    i_WR_EN = 1'b1;
    i_WR_ADDR = a[AB-1:0];
    i_WR_DATA = d;
    tick();
    i_WR_EN = 1'b0;
    mtbl[DBUF ? (mact ^ 1) : 0][a] = d;
  endtask

  task automatic swap_req;
    i_SWAP_REQ = 1'b1;
    tick();
    i_SWAP_REQ = 1'b0;
    if (DBUF) mpend = 1'b1;
    total++;
    if (o_SWAP_PEND !== DBUF) begin
      bad++;
      $display("FAIL swap_pend_set: got %b want %b", o_SWAP_PEND, DBUF);
    end
  endtask

  task automatic frame_start(input bit swap);
    i_FRAME_START = 1'b1;
    i_SWAP_REQ = swap;
    tick();
    i_FRAME_START = 1'b0;
    i_SWAP_REQ = 1'b0;
    if (DBUF && (mpend || swap)) mact ^= 1;
    mpend = 1'b0;
    mrow = 0;
    mfirst = 1'b1;
    tick();
    total += 2;
    if (o_COEFF_VLD !== 1'b0) begin
      bad++;
      $display("FAIL frame_vld_drop: got %b want 0", o_COEFF_VLD);
    end
    if (o_SWAP_PEND !== 1'b0) begin
      bad++;
      $display("FAIL frame_swap_clear: got %b want 0", o_SWAP_PEND);
    end
  endtask

  task automatic do_line(input bit with_fs, input bit pix, input string nm);
    int idx;
    logic [VB-1:0] exp;
    logic y_exp;
    i_LINE_START = 1'b1;
    i_FRAME_START = with_fs;
    tick();
    i_LINE_START = 1'b0;
    i_FRAME_START = 1'b0;
    if (with_fs) begin
      if (DBUF && mpend) mact ^= 1;
      mpend = 1'b0;
      mrow = 0;
    end else begin
      mrow = mfirst ? 0 : (mrow == (1 << RB) - 1 ? mrow : mrow + 1);
    end
    mfirst = 1'b0;
    if (pix) begin
      i_PIX_VALID = 1'b1;
      i_ERR_CLR = 1'b1;
      #1;
      total++;
      if (o_ENA_VEC[0] !== 1'b1) begin
        bad++;
        $display("FAIL %s ena0: got %b want 1", nm, o_ENA_VEC[0]);
      end
    end
    tick();
    i_PIX_VALID = 1'b0;
    i_ERR_CLR = 1'b0;
    total++;
    if (o_COEFF_VLD !== 1'b0) begin
      bad++;
      $display("FAIL %s vld_early: got %b want 0", nm, o_COEFF_VLD);
    end
    if (pix) begin
      total += 2;
      if (o_ERR !== 1'b1) begin
        bad++;
        $display("FAIL %s err_set_wins: got %b want 1", nm, o_ERR);
      end
      if (o_ENA_VEC[1] !== 1'b1) begin
        bad++;
        $display("FAIL %s ena1: got %b want 1", nm, o_ENA_VEC[1]);
      end
    end
    tick();
    idx = mrow >> i_REG_ROW_SFT;
    if (idx > 63) idx = 63;
    exp = mtbl[mact][idx];
    y_exp = (mrow % 2 == 1) ^ i_REG_Y_OFS;
    total += 4;
    if (o_COEFF_VLD !== 1'b1) begin
      bad++;
      $display("FAIL %s vld: got %b want 1", nm, o_COEFF_VLD);
    end
    if (o_COEFF_VEC !== exp) begin
      bad++;
      $display("FAIL %s coeff row %0d: got %h want %h", nm, mrow, o_COEFF_VEC, exp);
    end
    if (o_Y_LSB !== y_exp) begin
      bad++;
      $display("FAIL %s y_lsb row %0d: got %b want %b", nm, mrow, o_Y_LSB, y_exp);
    end
    if (o_ROW_IDX !== RB'(mrow)) begin
      bad++;
      $display("FAIL %s row_idx: got %0d want %0d", nm, o_ROW_IDX, mrow);
    end
    if (pix) begin
      i_PIX_VALID = 1'b1;
      i_ERR_CLR = 1'b1;
      tick();
      i_PIX_VALID = 1'b0;
      i_ERR_CLR = 1'b0;
      total++;
      if (o_ERR !== 1'b0) begin
        bad++;
        $display("FAIL %s err_clr_active: got %b want 0", nm, o_ERR);
      end
    end
    repeat ($urandom_range(0, 4)) tick();
  endtask

  task automatic check_reset_outs(input string nm);
    total += 7;
    if (o_COEFF_VEC !== '0) begin bad++; $display("FAIL %s coeff: got %h want 0", nm, o_COEFF_VEC); end
    if (o_COEFF_VLD !== 1'b0) begin bad++; $display("FAIL %s vld: got %b want 0", nm, o_COEFF_VLD); end
    if (o_Y_LSB !== 1'b0) begin bad++; $display("FAIL %s y_lsb: got %b want 0", nm, o_Y_LSB); end
    if (o_ENA_VEC !== 2'b00) begin bad++; $display("FAIL %s ena: got %b want 00", nm, o_ENA_VEC); end
    if (o_ROW_IDX !== '0) begin bad++; $display("FAIL %s row: got %0d want 0", nm, o_ROW_IDX); end
    if (o_SWAP_PEND !== 1'b0) begin bad++; $display("FAIL %s swap_pend: got %b want 0", nm, o_SWAP_PEND); end
    if (o_ERR !== 1'b0) begin bad++; $display("FAIL %s err: got %b want 0", nm, o_ERR); end
  endtask

  task automatic test_reset;
    check_reset_outs("reset");
    @(posedge i_CLK);
    #1 i_RSTn = 1'b1;
    tick();
    i_PIX_VALID = 1'b1;
    #1;
    total++;
    if (o_ENA_VEC[0] !== 1'b0) begin
      bad++;
      $display("FAIL idle_ena0: got %b want 0", o_ENA_VEC[0]);
    end
    tick();
    i_PIX_VALID = 1'b0;
    total++;
    if (o_ERR !== 1'b1) begin
      bad++;
      $display("FAIL idle_err: got %b want 1", o_ERR);
    end
    i_ERR_CLR = 1'b1;
    tick();
    i_ERR_CLR = 1'b0;
    total++;
    if (o_ERR !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b want 0", o_ERR);
    end
  endtask

  task automatic test_load;
    logic [9:0] r, g, b;
    for (int i = 0; i < 64; i++) begin
      r = 10'h100 + 10'(i);
      g = 10'h200 + 10'(i);
      b = 10'h300 + 10'(i);
      ld[i] = (i < 4) ? {b, g, r} : VB'($urandom);
    end
    for (int i = 0; i < 64; i++) wr(i, ld[i]);
    swap_req();
    frame_start(1'b0);
    for (int i = 0; i < 64; i++) wr(i, ld[i]);
  endtask

  task automatic test_rows;
    i_REG_ROW_SFT = 3'd0;
    i_REG_Y_OFS = 1'b0;
    frame_start(1'b0);
    for (int i = 0; i < 4; i++) do_line(1'b0, 1'b0, "rows");
  endtask

  task automatic test_shift;
    i_REG_ROW_SFT = 3'd2;
    frame_start(1'b0);
    for (int i = 0; i < 10; i++) do_line(1'b0, 1'b0, "shift2");
    i_REG_ROW_SFT = 3'd0;
    frame_start(1'b0);
    for (int i = 0; i < 67; i++) do_line(1'b0, 1'b0, "clamp");
    i_REG_ROW_SFT = 3'($urandom_range(1, 3));
    i_REG_Y_OFS = 1'($urandom);
    frame_start(1'b0);
    for (int i = 0; i < 12; i++) do_line(1'b0, 1'b0, "rand_sft");
    i_REG_Y_OFS = 1'b1;
    i_REG_ROW_SFT = 3'd0;
  endtask

  task automatic test_err;
    frame_start(1'b0);
    do_line(1'b0, 1'b1, "err_a");
    do_line(1'b0, 1'b1, "err_b");
  endtask

  task automatic test_fs_ls;
    do_line(1'b0, 1'b0, "pre_fsls");
    do_line(1'b1, 1'b0, "fsls");
    do_line(1'b0, 1'b0, "post_fsls");
  endtask

  task automatic test_back_to_back;
    i_REG_ROW_SFT = 3'd3;
    i_REG_Y_OFS = 1'b0;
    frame_start(1'b0);
    do_line(1'b0, 1'b0, "dbuf_row0");
    wr(0, {3{10'h3FF}});
    swap_req();
    do_line(1'b0, 1'b0, "dbuf_row1");
    total++;
    if (o_SWAP_PEND !== DBUF) begin
      bad++;
      $display("FAIL dbuf_pend_hold: got %b want %b", o_SWAP_PEND, DBUF);
    end
    frame_start(1'b0);
    do_line(1'b0, 1'b0, "dbuf_new");
    swap_req();
    frame_start(1'b1);
    do_line(1'b0, 1'b0, "dbuf_swap_same");
    i_REG_ROW_SFT = 3'd0;
  endtask

  task automatic test_reset_mid;
    frame_start(1'b0);
    do_line(1'b0, 1'b0, "pre_rst");
    do_line(1'b0, 1'b0, "pre_rst2");
    if (DBUF) swap_req();
    i_RSTn = 1'b0;
    #1;
    check_reset_outs("mid_reset");
    mact = 0;
    mpend = 1'b0;
    tick();
    i_RSTn = 1'b1;
    tick();
    do_line(1'b1, 1'b0, "post_rst");
    do_line(1'b0, 1'b0, "post_rst2");
  endtask

  initial begin
    total = 0;
    bad = 0;
    mact = 0;
    mrow = 0;
    mfirst = 1'b1;
    mpend = 1'b0;
    i_RSTn = 1'b0;
    i_WR_EN = 1'b0;
    i_WR_ADDR = '0;
    i_WR_DATA = '0;
    i_SWAP_REQ = 1'b0;
    i_FRAME_START = 1'b0;
    i_LINE_START = 1'b0;
    i_PIX_VALID = 1'b0;
    i_REG_ROW_SFT = '0;
    i_REG_Y_OFS = 1'b0;
    i_ERR_CLR = 1'b0;
    repeat (3) @(posedge i_CLK);
    #1;
    test_reset();
    test_load();
    test_rows();
    test_shift();
    test_err();
    test_fs_ls();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
